// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back arbiter: ALU results take priority, load results are buffered in a
// 2-entry FIFO, and a busy-bit scoreboard stalls decode on sources with pending loads.
module regfile_wb_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd_addr,
  input  logic [31:0] i_alu_rd_data,
  input  logic        i_lsu_valid,
  input  logic [4:0]  i_lsu_rd_addr,
  input  logic [31:0] i_lsu_rd_data,
  output logic        o_lsu_ready,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd_addr,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_stall,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren
);

  logic [4:0]  fifo_addr_q [2];
  logic [31:0] fifo_data_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] busy_q, busy_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_wren_q, rd_wren_d;
  logic        src_lsu_q, src_lsu_d;
  logic        lsu_accept, push, pop;

  // Ready comes from the registered count only, so it never depends on same-cycle inputs.
  assign o_lsu_ready = (count_q < 2'd2);
  assign lsu_accept  = i_lsu_valid && o_lsu_ready;

  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;
  assign o_rd_wren = rd_wren_q;

  assign o_stall = ((i_rs1_addr != 5'd0) && busy_q[i_rs1_addr]) ||
                   ((i_rs2_addr != 5'd0) && busy_q[i_rs2_addr]);

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_wren_d = 1'b0;
    src_lsu_d = src_lsu_q;
    push      = 1'b0;
    pop       = 1'b0;

    if (i_alu_valid) begin
      rd_addr_d = i_alu_rd_addr;
      rd_data_d = i_alu_rd_data;
      rd_wren_d = (i_alu_rd_addr != 5'd0);
      src_lsu_d = 1'b0;
      push      = lsu_accept;
    end else if (count_q != 2'd0) begin
      rd_addr_d = fifo_addr_q[rd_ptr_q];
      rd_data_d = fifo_data_q[rd_ptr_q];
      rd_wren_d = (fifo_addr_q[rd_ptr_q] != 5'd0);
      src_lsu_d = 1'b1;
      pop       = 1'b1;
      push      = lsu_accept;
    end else if (lsu_accept) begin
      rd_addr_d = i_lsu_rd_addr;
      rd_data_d = i_lsu_rd_data;
      rd_wren_d = (i_lsu_rd_addr != 5'd0);
      src_lsu_d = 1'b1;
    end

    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Clear for the load being written this cycle first, so a same-edge reservation wins.
    busy_d = busy_q;
    if (rd_wren_q && src_lsu_q) busy_d[rd_addr_q] = 1'b0;
    if (i_issue_valid && (i_issue_rd_addr != 5'd0)) busy_d[i_issue_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      busy_q    <= 32'd0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
      rd_wren_q <= 1'b0;
      src_lsu_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_wren_q <= rd_wren_d;
      src_lsu_q <= src_lsu_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_lsu_rd_addr;
      fifo_data_q[wr_ptr_q] <= i_lsu_rd_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: a queue-based write-back model is checked every cycle,
// with hand-computed expectations pinning each scenario.
module tb_regfile_wb_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_alu_valid = 1'b0;
  logic [4:0]  i_alu_rd_addr = '0;
  logic [31:0] i_alu_rd_data = '0;
  logic        i_lsu_valid = 1'b0;
  logic [4:0]  i_lsu_rd_addr = '0;
  logic [31:0] i_lsu_rd_data = '0;
  logic        o_lsu_ready;
  logic        i_issue_valid = 1'b0;
  logic [4:0]  i_issue_rd_addr = '0;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic        o_stall;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;

  regfile_wb_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_valid(i_alu_valid), .i_alu_rd_addr(i_alu_rd_addr), .i_alu_rd_data(i_alu_rd_data),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rd_addr(i_lsu_rd_addr), .i_lsu_rd_data(i_lsu_rd_data),
    .o_lsu_ready(o_lsu_ready),
    .i_issue_valid(i_issue_valid), .i_issue_rd_addr(i_issue_rd_addr),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .o_stall(o_stall),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t lsu_src[$];   // results the LSU still has to deliver
  ent_t m_fifo[$];    // model of buffered, accepted loads
  logic        m_wren = 1'b0;
  logic        m_lsu  = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_busy [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    return ((i_rs1_addr != 0) && m_busy[i_rs1_addr]) || ((i_rs2_addr != 0) && m_busy[i_rs2_addr]);
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic from_lsu);
    m_addr = a;
    m_data = d;
    m_wren = (a != 0);
    m_lsu  = from_lsu;
  endtask

  // Model update at each edge, then the per-cycle comparison once the DUT has settled.
  always @(posedge i_clk) begin
    if (i_rst) begin
      m_fifo.delete();
      m_wren = 1'b0; m_lsu = 1'b0; m_addr = '0; m_data = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      bit   acc;
      bit   clr;
      logic [4:0] clr_a;
      ent_t in_e;
      ent_t head;
      acc   = i_lsu_valid && (m_fifo.size() < 2);
      clr   = m_wren && m_lsu;
      clr_a = m_addr;
      in_e  = '{a: i_lsu_rd_addr, d: i_lsu_rd_data};
      if (i_alu_valid) begin
        model_write(i_alu_rd_addr, i_alu_rd_data, 1'b0);
        if (acc) m_fifo.push_back(in_e);
      end else if (m_fifo.size() > 0) begin
        head = m_fifo.pop_front();
        model_write(head.a, head.d, 1'b1);
        if (acc) m_fifo.push_back(in_e);
      end else if (acc) begin
        model_write(in_e.a, in_e.d, 1'b1);
      end else begin
        m_wren = 1'b0;
      end
      if (clr) m_busy[clr_a] = 1'b0;
      if (i_issue_valid && i_issue_rd_addr != 0) m_busy[i_issue_rd_addr] = 1'b1;
      if (acc && lsu_src.size() > 0) void'(lsu_src.pop_front());
    end
    #2;
    check("cyc_wren",  32'(o_rd_wren),   32'(m_wren));
    check("cyc_addr",  32'(o_rd_addr),   32'(m_addr));
    check("cyc_data",  o_rd_data,        m_data);
    check("cyc_ready", 32'(o_lsu_ready), 32'(m_fifo.size() < 2));
    check("cyc_stall", 32'(o_stall),     32'(model_stall()));
  end

  task automatic lsu_push(input logic [4:0] a, input logic [31:0] d);
    lsu_src.push_back('{a: a, d: d});
  endtask

  // Present one cycle of stimulus, applied at the falling edge.
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ia);
    @(negedge i_clk);
    i_alu_valid     = av;
    i_alu_rd_addr   = aa;
    i_alu_rd_data   = ad;
    i_issue_valid   = iv;
    i_issue_rd_addr = ia;
    i_lsu_valid     = (lsu_src.size() > 0);
    if (lsu_src.size() > 0) begin
      i_lsu_rd_addr = lsu_src[0].a;
      i_lsu_rd_data = lsu_src[0].d;
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;

    #1;
    check("rst_wren",  32'(o_rd_wren),   32'd0);
    check("rst_addr",  32'(o_rd_addr),   32'd0);
    check("rst_data",  o_rd_data,        32'd0);
    check("rst_ready", 32'(o_lsu_ready), 32'd1);
    check("rst_stall", 32'(o_stall),     32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // ALU only
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
    idle();
    check("alu_wren", 32'(o_rd_wren), 32'd1);
    check("alu_addr", 32'(o_rd_addr), 32'd5);
    check("alu_data", o_rd_data,      32'h1234);

    // ALU and LSU in the same cycle
    lsu_push(5'd4, 32'hAAAA);
    drive(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0);
    idle();
    check("cont_addr0", 32'(o_rd_addr),   32'd3);
    check("cont_ready", 32'(o_lsu_ready), 32'd1);
    idle();
    check("cont_wren1", 32'(o_rd_wren), 32'd1);
    check("cont_addr1", 32'(o_rd_addr), 32'd4);
    check("cont_data1", o_rd_data,      32'hAAAA);

    // Back-pressure: four ALU cycles against three loads
    lsu_push(5'd10, 32'h100);
    lsu_push(5'd11, 32'h101);
    lsu_push(5'd12, 32'h102);
    drive(1'b1, 5'd20, 32'h20, 1'b0, 5'd0);
    drive(1'b1, 5'd21, 32'h21, 1'b0, 5'd0);
    drive(1'b1, 5'd22, 32'h22, 1'b0, 5'd0);
    check("bp_ready0", 32'(o_lsu_ready), 32'd0);
    drive(1'b1, 5'd23, 32'h23, 1'b0, 5'd0);
    idle();
    check("bp_alu23", 32'(o_rd_addr), 32'd23);
    idle();
    check("bp_ld10", 32'(o_rd_addr), 32'd10);
    idle();
    check("bp_ld11",  32'(o_rd_addr),   32'd11);
    check("bp_ready", 32'(o_lsu_ready), 32'd1);
    idle();
    check("bp_ld12",  32'(o_rd_addr), 32'd12);
    check("bp_data",  o_rd_data,      32'h102);

    // Scoreboard: reserve x7, then release it with a load write
    i_rs1_addr = 5'd7;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    idle();
    check("sb_stall_set", 32'(o_stall), 32'd1);
    lsu_push(5'd7, 32'h77);
    idle();
    idle();
    check("sb_wr7",        32'(o_rd_addr), 32'd7);
    check("sb_stall_hold", 32'(o_stall),   32'd1);
    idle();
    check("sb_stall_clr", 32'(o_stall), 32'd0);

    // Re-issue of x7 on the edge that retires the old load keeps the stall
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    lsu_push(5'd7, 32'h78);
    idle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    check("sb_rewr7", 32'(o_rd_wren), 32'd1);
    idle();
    check("sb_set_wins", 32'(o_stall), 32'd1);
    lsu_push(5'd7, 32'h79);
    idle();
    idle();
    idle();
    check("sb_stall_clr2", 32'(o_stall), 32'd0);
    i_rs1_addr = 5'd0;

    // x0 load is dropped from the write port but still drains the FIFO
    lsu_push(5'd0, 32'hDEAD);
    lsu_push(5'd13, 32'hD0D0);
    drive(1'b1, 5'd21, 32'h2121, 1'b0, 5'd0);
    drive(1'b1, 5'd22, 32'h2222, 1'b0, 5'd0);
    idle();
    idle();
    check("x0_wren",  32'(o_rd_wren),   32'd0);
    check("x0_ready", 32'(o_lsu_ready), 32'd1);
    idle();
    check("x0_next", 32'(o_rd_addr), 32'd13);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    idle();
    check("x0_nostall", 32'(o_stall), 32'd0);

    // Reset with a full FIFO and x9 reserved
    i_rs1_addr = 5'd9;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    lsu_push(5'd14, 32'h1414);
    lsu_push(5'd15, 32'h1515);
    drive(1'b1, 5'd24, 32'h24, 1'b0, 5'd0);
    drive(1'b1, 5'd25, 32'h25, 1'b0, 5'd0);
    drive(1'b1, 5'd26, 32'h26, 1'b0, 5'd0);
    check("pre_rst_full",  32'(o_lsu_ready), 32'd0);
    check("pre_rst_stall", 32'(o_stall),     32'd1);
    lsu_src.delete();
    i_alu_valid = 1'b0;
    i_lsu_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    check("mrst_wren",  32'(o_rd_wren),   32'd0);
    check("mrst_ready", 32'(o_lsu_ready), 32'd1);
    check("mrst_stall", 32'(o_stall),     32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    idle();
    check("post_rst_wren", 32'(o_rd_wren), 32'd0);
    for (int i = 0; i < 4; i++) idle();
    check("post_rst_stall", 32'(o_stall), 32'd0);

    i_rs1_addr = 5'd0;
    for (int i = 0; i < 40 && (lsu_src.size() > 0 || m_fifo.size() > 0); i++) idle();
    check("drain_done", 32'(lsu_src.size() + m_fifo.size()), 32'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports i_clk and i_rst are listed first below.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_alu_valid  in  1  single-cycle ALU result present; never back-pressured.
- i_alu_rd_addr  in  5  ALU destination register.
- i_alu_rd_data  in  32  ALU result.
- i_lsu_valid  in  1  long-latency (load) result present.
- i_lsu_rd_addr  in  5  load destination register.
- i_lsu_rd_data  in  32  load data.
- o_lsu_ready  out  1  block accepts the LSU result this cycle.
- i_issue_valid  in  1  long-latency op issued this cycle; reserves its destination.
- i_issue_rd_addr  in  5  destination of the issued op.
- i_rs1_addr  in  5  decode-stage source 1.
- i_rs2_addr  in  5  decode-stage source 2.
- o_stall  out  1  decode must hold; a source is reserved.
- o_rd_addr  out  5  register-file write address.
- o_rd_data  out  32  register-file write data.
- o_rd_wren  out  1  register-file write enable.
REQ-003 o_rd_addr, o_rd_data and o_rd_wren SHALL be registered and drive the register-file write port directly.

Function
REQ-004 LSU handshake: a transfer occurs when i_lsu_valid && o_lsu_ready; the LSU holds its inputs stable until the transfer.
REQ-005 o_lsu_ready SHALL equal (FIFO count < 2) and SHALL NOT depend on any input in the same cycle.
REQ-006 The LSU buffer SHALL be a 2-entry FIFO (addr+data) with in-order drain.
REQ-007 Output register load priority at each edge:
- 1: ALU when i_alu_valid.
- 2: else the FIFO head (popped).
- 3: else the accepted LSU input (bypass, not pushed).
- 4: else o_rd_wren <= 0, with o_rd_addr and o_rd_data held.
REQ-008 An accepted LSU result not consumed by priority 3 SHALL be pushed; a simultaneous push and pop SHALL keep the count unchanged.
REQ-009 Latency:
- ALU result: o_rd_wren high exactly 1 cycle after i_alu_valid.
- LSU result with empty FIFO and no ALU traffic: 1 cycle.
- Otherwise: 1 cycle plus 1 per ALU-occupied cycle and per older FIFO entry.
REQ-010 A write whose address is 0 SHALL be loaded with o_rd_wren=0; it still consumes its slot and pops the FIFO.
REQ-011 Scoreboard:
- 32 busy bits; bit 0 is constant 0.
- i_issue_valid with a non-zero address sets busy[i_issue_rd_addr] at the edge.
REQ-012 busy[a] SHALL clear at the edge where o_rd_wren=1 with o_rd_addr=a and the output register holds an LSU-sourced entry. An internal source flag is registered with the output.
REQ-013 When a set and a clear of the same bit occur at the same edge, the set SHALL win.
REQ-014 o_stall SHALL be combinational: (rs1≠0 && busy[rs1]) || (rs2≠0 && busy[rs2]).
REQ-015 LSU entries SHALL never be dropped or reordered. ALU writes MAY overtake queued LSU writes; the scoreboard prevents use of stale data.
REQ-016 An LSU result arriving while the FIFO is full SHALL be held off by o_lsu_ready=0; no overflow path exists.

Reset
REQ-017 While i_rst is high, independent of i_clk:
- o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
- FIFO emptied; all busy bits cleared.
- o_stall=0 and o_lsu_ready=1.
REQ-018 Reset asserted mid-operation SHALL discard all queued LSU entries and reservations, and no write SHALL issue in the cycle after deassertion.

Verification
REQ-019 Bench scenarios:
- ALU only: i_alu_valid, rd=5, data=0x1234 -> next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0x1234.
- Contention: ALU rd=3 and LSU rd=4 valid in the same cycle -> cycle+1 writes x3; cycle+2 writes x4 from the FIFO; o_lsu_ready stays 1.
- Back-pressure: ALU valid for 4 cycles while LSU offers 3 results -> o_lsu_ready=0 after 2 accepted; the 3rd is accepted after the first drain; writes occur in LSU order.
- Scoreboard: issue rd=7, then i_rs1_addr=7 -> o_stall=1 until the edge where the LSU write to x7 occurs, then 0. Issue of rd=7 on that same edge -> o_stall remains 1.
- x0: LSU result with rd=0 -> o_rd_wren=0 and FIFO count decrements; issue of rd=0 never stalls.
- Reset mid-run: FIFO holds 2 entries and busy[9]=1; pulse i_rst -> o_rd_wren=0, o_lsu_ready=1, o_stall=0, and no queued write appears afterwards.
